// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared state type and default WS2812 timing for the LED bit encoder
package led_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        LATCH = 2'd3
    } led_state_e;

    localparam int BITS_PER_LED = 24;

    // 50 MHz system clock
    localparam int DEF_T0H     = 20;
    localparam int DEF_T1H     = 40;
    localparam int DEF_T_BIT   = 63;
    localparam int DEF_T_RESET = 2500;
    localparam int DEF_N_LEDS  = 8;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - loadable down-counter; expired_o while the count sits at zero
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] count_o,
    output logic         expired_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign count_o   = count_q;
    assign expired_o = (count_q == '0);

endmodule

// File: rtl/led_bit_encoder.sv
// rtl/led_bit_encoder.sv - WS2812-style one-wire NRZ encoder with latch gap
// Optional: LED_BIT_ENCODER_AUTO_RESTART_EN restarts straight from LATCH when start is high.
module led_bit_encoder
    import led_pkg::*;
#(
    parameter int T0H     = DEF_T0H,
    parameter int T1H     = DEF_T1H,
    parameter int T_BIT   = DEF_T_BIT,
    parameter int T_RESET = DEF_T_RESET,
    parameter int N_LEDS  = DEF_N_LEDS
) (
    input  logic clk,
    input  logic rstn,
    input  logic start,
    input  logic bit_in,
    output logic bit_rqst,
    output logic frame_rqst,
    output logic dout,
    output logic busy,
    output logic done
);

    localparam int CW = $clog2(max2(T_BIT, T_RESET) + 1);
    localparam int LW = $clog2(N_LEDS + 1);

    localparam logic [CW-1:0] BIT_LAST   = CW'(T_BIT - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(T_RESET - 1);
    localparam logic [CW-1:0] HI0_END    = CW'(T_BIT - T0H);
    localparam logic [CW-1:0] HI1_END    = CW'(T_BIT - T1H);
    localparam logic [LW-1:0] LED_LAST   = LW'(N_LEDS - 1);
    localparam logic [4:0]    BIT_LAST_IDX = 5'(BITS_PER_LED - 1);

    led_state_e    state_q;
    logic          bit_q;
    logic          first_q;
    logic [4:0]    bit_cnt_q;
    logic [LW-1:0] led_cnt_q;
    logic          bit_rqst_q, frame_rqst_q, dout_q, busy_q, done_q;

    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic [CW-1:0] tmr_cnt;
    logic          tmr_exp;

    logic cur_bit, high_end, bit_end, last_bit, latch_end, restart, begin_refresh, rqst_next;

    // One timer spans the whole bit period, so the HIGH/LOW split is a compare on the remaining count.
    always_comb begin
        cur_bit       = first_q ? bit_in : bit_q;
        high_end      = (state_q == HIGH) && (tmr_cnt == (cur_bit ? HI1_END : HI0_END));
        bit_end       = (state_q == LOW) && tmr_exp;
        last_bit      = bit_end && (bit_cnt_q == BIT_LAST_IDX) && (led_cnt_q == LED_LAST);
        latch_end     = (state_q == LATCH) && tmr_exp;
`ifdef LED_BIT_ENCODER_AUTO_RESTART_EN
        restart       = latch_end && start;
`else
        restart       = 1'b0;
`endif
        begin_refresh = ((state_q == IDLE) && start) || restart;
        tmr_load      = begin_refresh || bit_end;
        tmr_val       = last_bit ? LATCH_LAST : BIT_LAST;
        rqst_next     = ((state_q == HIGH) || (state_q == LOW)) && (tmr_cnt == CW'(1));
    end

    cycle_timer #(.W(CW)) u_timer (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .count_o    (tmr_cnt),
        .expired_o  (tmr_exp)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            bit_q        <= 1'b0;
            first_q      <= 1'b0;
            bit_cnt_q    <= '0;
            led_cnt_q    <= '0;
            bit_rqst_q   <= 1'b0;
            frame_rqst_q <= 1'b0;
            dout_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            // Pulses are raised one cycle early so they land on the bit's end cycle.
            bit_rqst_q   <= rqst_next;
            frame_rqst_q <= rqst_next && (bit_cnt_q == BIT_LAST_IDX);
            done_q       <= ((state_q == LATCH) && (tmr_cnt == CW'(1))) || (last_bit && (T_RESET == 1));
            first_q      <= 1'b0;
            if (first_q) begin
                bit_q <= bit_in;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= HIGH;
                        dout_q    <= 1'b1;
                        busy_q    <= 1'b1;
                        bit_q     <= bit_in;
                        bit_cnt_q <= '0;
                        led_cnt_q <= '0;
                    end
                end
                HIGH: begin
                    if (high_end) begin
                        state_q <= LOW;
                        dout_q  <= 1'b0;
                    end
                end
                LOW: begin
                    if (bit_end) begin
                        if (bit_cnt_q == BIT_LAST_IDX) begin
                            bit_cnt_q <= '0;
                            led_cnt_q <= led_cnt_q + 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                        if (last_bit) begin
                            state_q <= LATCH;
                        end else begin
                            state_q <= HIGH;
                            dout_q  <= 1'b1;
                            first_q <= 1'b1;
                        end
                    end
                end
                LATCH: begin
                    if (latch_end) begin
                        if (restart) begin
                            state_q   <= HIGH;
                            dout_q    <= 1'b1;
                            bit_q     <= bit_in;
                            bit_cnt_q <= '0;
                            led_cnt_q <= '0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bit_rqst   = bit_rqst_q;
    assign frame_rqst = frame_rqst_q;
    assign dout       = dout_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_led_bit_encoder.sv
// tb/tb_led_bit_encoder.sv - randomized scoreboard bench for led_bit_encoder
module tb_led_bit_encoder;

    localparam int T0H     = 2;
    localparam int T1H     = 4;
    localparam int T_BIT   = 6;
    localparam int T_RESET = 10;
    localparam int N_LEDS  = 2;
    localparam int NB      = N_LEDS * 24;
    localparam int TOTAL   = NB * T_BIT + T_RESET;
`ifdef LED_BIT_ENCODER_AUTO_RESTART_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 2;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic start = 1'b0;
    logic bit_in = 1'b0;
    logic bit_rqst, frame_rqst, dout, busy, done;

    led_bit_encoder #(
        .T0H(T0H), .T1H(T1H), .T_BIT(T_BIT), .T_RESET(T_RESET), .N_LEDS(N_LEDS)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .bit_in(bit_in),
        .bit_rqst(bit_rqst), .frame_rqst(frame_rqst), .dout(dout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [NB-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;
    int timeouts = 0;
    bit gap_chk = 1'b0;
    bit stim_done = 1'b0;
    bit mon_done = 1'b0;

    // monitor state
    bit in_ref = 1'b0;
    bit rst_seen = 1'b0;
    int t_mon = 0;
    int since_done = 1000;
    int nrq = 0;
    int bi, ph;
    logic [NB-1:0] cur = '0;
    logic [4:0] act, expv;

    task automatic check(input string name, input int got, input int req);
        n_checks++;
        if (got == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d at t=%0t", name, got, req, $time);
    endtask

    // Reference: each bit is T1H/T0H high then low to T_BIT, then T_RESET low with done on the last cycle.
    initial begin : monitor
        forever begin
            @(negedge clk or negedge rstn);
            if (!rstn && !rst_seen) begin
                rst_seen = 1'b1;
                in_ref = 1'b0;
                #1;
                check("async_reset", int'({dout, busy, bit_rqst, frame_rqst, done}), 0);
            end else if (!clk) begin
                if (rstn) rst_seen = 1'b0;
                act = {dout, busy, bit_rqst, frame_rqst, done};
                if (!in_ref && dout === 1'b1) begin
                    check("refresh_queued", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) cur = exp_q.pop_front();
                    if (gap_chk) check("restart_gap", since_done, GAP);
                    in_ref = 1'b1;
                    t_mon = 1;
                    nrq = 0;
                end
                if (in_ref) begin
                    if (t_mon <= NB * T_BIT) begin
                        bi = (t_mon - 1) / T_BIT;
                        ph = (t_mon - 1) % T_BIT;
                        expv = {ph < (cur[bi] ? T1H : T0H), 1'b1, ph == T_BIT - 1,
                                (ph == T_BIT - 1) && (bi % 24 == 23), 1'b0};
                    end else begin
                        expv = {1'b0, 1'b1, 1'b0, 1'b0, t_mon == TOTAL};
                    end
                    nrq += int'(bit_rqst);
                    if (t_mon == TOTAL) begin
                        check("bit_rqst_count", nrq, NB);
                        in_ref = 1'b0;
                        since_done = 0;
                    end else begin
                        t_mon++;
                    end
                end else begin
                    expv = '0;
                end
                check("outputs{dout,busy,bit_rqst,frame_rqst,done}", int'(act), int'(expv));
                since_done++;
                if (stim_done && !mon_done) begin
                    check("driver_timeouts", timeouts, 0);
                    check("queue_drained", exp_q.size(), 0);
                    mon_done = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NB-1:0] gen(input int mode);
        logic [NB-1:0] v;
        for (int i = 0; i < NB; i++) begin
            case (mode)
                0:       v[i] = 1'b1;
                1:       v[i] = i[0];
                2:       v[i] = 1'($urandom_range(0, 1));
                default: v[i] = 1'b0;
            endcase
        end
        return v;
    endfunction

    // Acts as the frame transmitter: next bit appears the cycle after bit_rqst, noise otherwise.
    task automatic run(input int nref, input int mode, input bit hold, input bit noise, input int rst_at);
        logic [NB-1:0] bits;
        int t, k;
        bit pend, fin;
        for (int r = 0; r < nref; r++) begin
            bits = gen(mode);
            exp_q.push_back(bits);
            bit_in = bits[0];
            start = 1'b1;
            if (r == 0) begin
                step();
                if (!hold) start = 1'b0;
            end else begin
                gap_chk = 1'b1;
                k = 0;
                while (dout !== 1'b1 && k < 4) begin
                    step();
                    k++;
                end
                if (dout !== 1'b1) begin
                    timeouts++;
                    start = 1'b0;
                    return;
                end
            end
            k = 1;
            pend = 1'b0;
            t = 1;
            fin = 1'b0;
            while (!fin) begin
                if (t == 2) gap_chk = 1'b0;
                bit_in = (pend && k < NB) ? bits[k] : 1'($urandom_range(0, 1));
                if (pend && k < NB) k++;
                pend = bit_rqst;
                if (!hold) start = noise && t > 1 && t < TOTAL - 3 && $urandom_range(0, 7) == 0;
                if (t == rst_at) begin
                    #1 rstn = 1'b0;
                    start = 1'b0;
                    repeat (3) @(posedge clk);
                    @(negedge clk);
                    rstn = 1'b1;
                    step();
                    return;
                end
                if (done === 1'b1) begin
                    fin = 1'b1;
                end else if (t > TOTAL + 5) begin
                    timeouts++;
                    start = 1'b0;
                    return;
                end else begin
                    step();
                    t++;
                end
            end
        end
        start = 1'b0;
        step();
        step();
    endtask

    initial begin : driver
        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        repeat (20) step();
        run(1, 0, 1'b0, 1'b0, 0);
        run(1, 1, 1'b0, 1'b1, 0);
        run(1, 2, 1'b0, 1'b1, 0);
        run(2, 2, 1'b1, 1'b0, 0);
        run(1, 2, 1'b0, 1'b0, 10 * T_BIT + 3);
        run(1, 2, 1'b0, 1'b1, 0);
        run(1, 1, 1'b0, 1'b0, NB * T_BIT + 5);
        run(1, 3, 1'b0, 1'b0, 0);
        repeat (10) step();
        stim_done = 1'b1;
        repeat (4) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/led_bit_encoder.md
# led_bit_encoder

Serial line encoder for the LED strip: converts the bit stream produced by the frame transmitter into the one-wire NRZ pulse waveform (WS2812-style 0/1 codes plus latch/reset gap). Sits directly downstream of the frame transmitter. Drives its bit-advance and frame-advance requests, and owns the physical data pin. One start pulse sends a complete refresh of N_LEDS × 24 bits, followed by the latch gap.

## Interface
- T0H, default 20: high-time cycles for a 0 bit (400 ns @ 50 MHz)
- T1H, default 40: high-time cycles for a 1 bit (800 ns)
- T_BIT, default 63: total bit period in cycles (~1.25 µs)
- T_RESET, default 2500: latch low time in cycles (50 µs)
- N_LEDS, default 8: LEDs per refresh
- Constraint: 0 < T0H < T1H < T_BIT; T_RESET ≥ 1; N_LEDS ≥ 1
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  begin a refresh (level sampled in IDLE only)
- bit_in  in  1  current bit from frame transmitter (bit_to_transmit)
- bit_rqst  out  1  one-cycle pulse: advance to next bit (→ new_bit_rqst)
- frame_rqst  out  1  one-cycle pulse: advance to next LED frame (→ new_frame_rqst)
- dout  out  1  serial data line to strip
- busy  out  1  high from first HIGH cycle through end of LATCH
- done  out  1  one-cycle pulse when latch gap completes

## Operation
- States: IDLE, HIGH, LOW, LATCH.
- IDLE: dout=0, busy=0. On start=1 → HIGH; bit counter=0, LED counter=0, cycle counter=0; bit_in captured into a bit register on this same cycle.
- HIGH: dout=1 for T1H cycles if captured bit=1, else T0H cycles → LOW.
- LOW: dout=0 until the bit period totals T_BIT cycles. The last LOW cycle is the bit's end cycle:
  - bit_rqst=1 on every bit's end cycle.
  - If bit counter=23: frame_rqst=1 also; bit counter clears; LED counter increments.
  - If LED counter=N_LEDS-1 and bit counter=23 → LATCH; else → HIGH, capturing bit_in on the cycle after the bit_rqst pulse, i.e. the first HIGH cycle.
- LATCH: dout=0 for T_RESET cycles. On the final cycle: done=1, → IDLE.
- start is ignored outside IDLE.
- bit_in is sampled once per bit only; changes at other times have no effect.
- Reset (any time, including mid-bit or mid-latch): state=IDLE, all counters 0, dout=0, busy=0, bit_rqst=frame_rqst=done=0.
- Counter widths:
  - cycle counter: $clog2(max(T_BIT, T_RESET)+1)
  - bit counter: 5 bits, wraps at 23
  - LED counter: $clog2(N_LEDS+1)
  - No counter overflows for legal parameters.

## Timing
- Reset values: dout=0, busy=0, bit_rqst=0, frame_rqst=0, done=0.
- start sampled at edge n → dout=1, busy=1 from n+1.
- Each bit occupies exactly T_BIT cycles; there is no gap between bits.
- bit_rqst and frame_rqst are registered. Upstream must present the new bit_in within one cycle after the pulse; the frame transmitter meets this.
- Total refresh: N_LEDS×24×T_BIT + T_RESET cycles from first HIGH to done pulse.
- done is coincident with the last LATCH cycle. busy falls the cycle after done.
- All outputs are registered.

## Configuration
- LED_BIT_ENCODER_AUTO_RESTART_EN
  - Defined: after LATCH, the block returns directly to HIGH (new refresh, counters cleared, done still pulses) whenever start is high on the done cycle. busy stays high across the restart.
  - Undefined: LATCH always returns to IDLE; a new start is needed one cycle later.

## Structure
- Shared package led_pkg:
  - state enum (IDLE, HIGH, LOW, LATCH)
  - BITS_PER_LED=24
  - default timing constants (T0H/T1H/T_BIT/T_RESET at 50 MHz)
- One sub-module: cycle_timer, a loadable down-counter with an expire flag. It is reused for bit-phase timing and latch timing.

## Test plan
Bench params: T0H=2, T1H=4, T_BIT=6, T_RESET=10, N_LEDS=2.
- Reset then idle 20 cycles → dout=0, busy=0, no pulses.
- start pulse, bit_in held 1 → every bit: 4 cycles high, 2 low; 48 bit_rqst pulses 6 cycles apart; frame_rqst at bits 24 and 48; done at cycle 288+10 after start; busy falls next cycle.
- bit_in alternating 0/1 per bit_rqst → high times alternate 2/4 cycles; bit_in toggled mid-bit has no effect.
- start held high throughout:
  - without macro: IDLE for 1 cycle, then a second refresh.
  - with macro: no IDLE cycle; HIGH immediately follows LATCH.
- rstn asserted mid-bit 10 and again mid-LATCH → outputs drop to 0 asynchronously; next start sends a full 48-bit refresh from bit 0.
- start pulsed while busy → ignored; bit_rqst count remains 48.
